// File: rtl/mips_store_buffer.sv
// Posted-write store buffer between the datapath's load/store path and the
// word-addressed data memory. Stores are queued and drained on cycles
// without a load. Loads are served from the youngest matching queued store,
// or from memory when no queued store matches.
module mips_store_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic          cpu_mem_read,
    input  logic          cpu_mem_write,
    input  logic [2:0]    cpu_memctr,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_stall,
    output logic [31:0]   mem_address,
    output logic [31:0]   mem_write_data,
    output logic          mem_read,
    output logic          mem_write,
    output logic [2:0]    mem_ctr,
    input  logic [31:0]   mem_read_data,
    output logic [CW-1:0] sb_count,
    output logic          sb_empty
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] CTR_LW  = 3'b000;
    localparam logic [2:0] CTR_LBU = 3'b001;
    localparam logic [2:0] CTR_LHU = 3'b010;
    localparam logic [2:0] CTR_SW  = 3'b100;
    localparam logic [2:0] CTR_SB  = 3'b101;
    localparam logic [2:0] CTR_SH  = 3'b111;

    logic [31:0]   ent_addr [DEPTH];
    logic [31:0]   ent_data [DEPTH];
    logic [2:0]    ent_ctr  [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;

    logic          store_ctr_ok;
    logic          load_ctr_ok;
    logic          is_store;
    logic          full;
    logic          enq;
    logic          drain;
    logic          load_owns_port;
    logic          fwd_hit;
    logic [31:0]   fwd_word;
    logic [AW-1:0] scan_idx;

    // Value a queued store will leave in its memory word (zero-extended,
    // matching the memory's byte/halfword write behaviour for forwarding).
    function automatic logic [31:0] store_word(input logic [31:0] data,
                                               input logic [2:0]  ctr);
        logic [31:0] w;
        w = data;
        if (ctr == CTR_SB) w = {24'b0, data[7:0]};
        else if (ctr == CTR_SH) w = {16'b0, data[15:0]};
        return w;
    endfunction

    assign store_ctr_ok = (cpu_memctr == CTR_SW) || (cpu_memctr == CTR_SB) ||
                          (cpu_memctr == CTR_SH);
    assign load_ctr_ok  = (cpu_memctr == CTR_LW) || (cpu_memctr == CTR_LBU) ||
                          (cpu_memctr == CTR_LHU);

    // A simultaneous read+write request is treated as a load only.
    assign is_store  = cpu_mem_write & ~cpu_mem_read & store_ctr_ok;
    assign full      = (count == CW'(DEPTH));
    assign enq       = is_store & ~full;
    assign cpu_stall = is_store & full;

    // Scan valid entries oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_word = '0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head + AW'(k);
            if ((CW'(k) < count) && (ent_addr[scan_idx] == cpu_addr)) begin
                fwd_hit  = 1'b1;
                fwd_word = store_word(ent_data[scan_idx], ent_ctr[scan_idx]);
            end
        end
    end

    // A missing load takes the memory port; otherwise the head drains.
    assign load_owns_port = cpu_mem_read & ~fwd_hit;
    assign drain          = ~load_owns_port & (count != '0);

    // Memory port mux.
    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_ctr        = '0;
        if (load_owns_port) begin
            mem_read    = 1'b1;
            mem_address = cpu_addr;
            mem_ctr     = cpu_memctr;
        end else if (drain) begin
            mem_write      = 1'b1;
            mem_address    = ent_addr[head];
            mem_write_data = ent_data[head];
            mem_ctr        = ent_ctr[head];
        end
    end

    // Load result: forwarded word is re-extracted by load type; memory data
    // arrives already extracted.
    always_comb begin
        cpu_rdata = '0;
        if (cpu_mem_read && load_ctr_ok) begin
            if (fwd_hit) begin
                unique case (cpu_memctr)
                    CTR_LBU: cpu_rdata = {24'b0, fwd_word[7:0]};
                    CTR_LHU: cpu_rdata = {16'b0, fwd_word[15:0]};
                    default: cpu_rdata = fwd_word;
                endcase
            end else begin
                cpu_rdata = mem_read_data;
            end
        end
    end

    // Entry storage; validity comes from head/count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_addr[tail] <= cpu_addr;
            ent_data[tail] <= cpu_wdata;
            ent_ctr[tail]  <= cpu_memctr;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq)   tail <= tail + AW'(1);
            if (drain) head <= head + AW'(1);
            unique case ({enq, drain})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign sb_count = count;
    assign sb_empty = (count == '0);

endmodule
